fpu_op_sequencer: RTL and testbench

FPU_OP_SEQUENCER -- requirements
Module: fpu_op_sequencer

---
 rtl/fpu_pkg.sv | 53 +++++
 rtl/fpu_lat_counter.sv | 25 ++
 rtl/fpu_op_sequencer.sv | 126 ++++++++++++
 tb/tb_fpu_op_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU op-code constants, sequencer state type and decode helpers.
// Used by the sequencer and by the instruction decoder.
package fpu_pkg;

    localparam logic [3:0] OP_ADD     = 4'd0;
    localparam logic [3:0] OP_SUB     = 4'd1;
    localparam logic [3:0] OP_MUL     = 4'd2;
    localparam logic [3:0] OP_DIV     = 4'd3;
    localparam logic [3:0] OP_CMP_EQ  = 4'd4;
    localparam logic [3:0] OP_CMP_LT  = 4'd5;
    localparam logic [3:0] OP_CMP_LE  = 4'd6;
    localparam logic [3:0] OP_I2F_W   = 4'd7;
    localparam logic [3:0] OP_F2I_W   = 4'd8;
    localparam logic [3:0] OP_I2F_WU  = 4'd9;
    localparam logic [3:0] OP_F2I_WU  = 4'd10;
    localparam logic [3:0] OP_SGNJ    = 4'd11;
    localparam logic [3:0] OP_SGNJN   = 4'd12;
    localparam logic [3:0] OP_SGNJX   = 4'd13;
    localparam logic [3:0] OP_RSVD14  = 4'd14;
    localparam logic [3:0] OP_INVALID = 4'd15;

    typedef enum logic [1:0] {
        CLS_SINGLE  = 2'd0,
        CLS_MULTI   = 2'd1,
        CLS_INVALID = 2'd2
    } fpu_class_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } fpu_state_e;

    function automatic fpu_class_e op_class(input logic [3:0] code);
        fpu_class_e cls;
        case (code)
            OP_MUL, OP_DIV: cls = CLS_MULTI;
            OP_ADD, OP_SUB, OP_CMP_EQ, OP_CMP_LT, OP_CMP_LE,
            OP_I2F_W, OP_F2I_W, OP_I2F_WU, OP_F2I_WU,
            OP_SGNJ, OP_SGNJN, OP_SGNJX: cls = CLS_SINGLE;
            OP_RSVD14, OP_INVALID: cls = CLS_INVALID;
            default: cls = CLS_INVALID;
        endcase
        return cls;
    endfunction

    // Compares and float-to-int conversions produce integer results.
    function automatic logic wb_is_xreg(input logic [3:0] code);
        return (code == OP_CMP_EQ) || (code == OP_CMP_LT) || (code == OP_CMP_LE) ||
               (code == OP_F2I_W) || (code == OP_F2I_WU);
    endfunction

endpackage

// File: rtl/fpu_lat_counter.sv
// 4-bit latency down-counter: loadable, saturates at zero, reports zero.
module fpu_lat_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       en,
    input  logic [3:0] load_val,
    output logic       zero
);

    logic [3:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 4'd0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != 4'd0)) begin
            count <= count - 4'd1;
        end
    end

    assign zero = (count == 4'd0);

endmodule

// File: rtl/fpu_op_sequencer.sv
// FPU issue sequencer: single-cycle ops write back immediately, mul/div
// stall the pipeline for their latency, then write back in a DONE cycle.
module fpu_op_sequencer
    import fpu_pkg::*;
#(
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 12
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       FPU_OP,
    input  logic [3:0] FPU_CONTROL,
    input  logic       FLUSH,
    output logic       STALL,
    output logic       UNIT_START,
    output logic [3:0] UNIT_CTRL,
    output logic       FREG_WE,
    output logic       XREG_WE,
    output logic       ILLEGAL,
    output fpu_state_e dbg_state
);

    // Handshake: FPU_OP is the valid; STALL is the inverse of ready. An
    // instruction is consumed in the first cycle FPU_OP=1 with STALL=0, and
    // the core holds FPU_OP/FPU_CONTROL stable for as long as STALL=1.

    fpu_state_e state, next_state;
    fpu_class_e op_cls;
    logic [3:0] code_q;
    logic [3:0] lat_m1;
    logic       cnt_load, cnt_en, cnt_zero;

    assign op_cls = op_class(FPU_CONTROL);
    assign lat_m1 = (FPU_CONTROL == OP_DIV) ? 4'(DIV_LAT - 1) : 4'(MUL_LAT - 1);

    fpu_lat_counter u_lat_counter (
        .clk      (CLK),
        .rst_n    (RST),
        .load     (cnt_load),
        .en       (cnt_en),
        .load_val (lat_m1),
        .zero     (cnt_zero)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state  <= ST_IDLE;
            code_q <= 4'd0;
        end else begin
            state <= next_state;
            if (cnt_load) begin
                code_q <= FPU_CONTROL;
            end
        end
    end

    always_comb begin
        next_state = state;
        STALL      = 1'b0;
        UNIT_START = 1'b0;
        UNIT_CTRL  = FPU_CONTROL;
        FREG_WE    = 1'b0;
        XREG_WE    = 1'b0;
        ILLEGAL    = 1'b0;
        cnt_load   = 1'b0;
        cnt_en     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (FPU_OP) begin
                    case (op_cls)
                        CLS_SINGLE: begin
                            XREG_WE = wb_is_xreg(FPU_CONTROL);
                            FREG_WE = !wb_is_xreg(FPU_CONTROL);
                        end
                        CLS_MULTI: begin
                            STALL      = 1'b1;
                            UNIT_START = 1'b1;
                            cnt_load   = 1'b1;
                            next_state = ST_BUSY;
                        end
                        default: ILLEGAL = 1'b1;
                    endcase
                end
            end
            ST_BUSY: begin
                STALL     = 1'b1;
                UNIT_CTRL = code_q;
                cnt_en    = 1'b1;
                if (cnt_zero) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                // The stalled instruction retires here; FPU_OP is not re-decoded.
                UNIT_CTRL  = code_q;
                FREG_WE    = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase

        if (FLUSH) begin
            next_state = ST_IDLE;
            STALL      = 1'b0;
            UNIT_START = 1'b0;
            FREG_WE    = 1'b0;
            XREG_WE    = 1'b0;
            ILLEGAL    = 1'b0;
            cnt_load   = 1'b0;
            cnt_en     = 1'b0;
        end

        // Outputs must be quiet for the whole time reset is held, not just after an edge.
        if (!RST) begin
            STALL      = 1'b0;
            UNIT_START = 1'b0;
            FREG_WE    = 1'b0;
            XREG_WE    = 1'b0;
            ILLEGAL    = 1'b0;
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Directed bench for fpu_op_sequencer: per-instruction expected output
// schedules are derived from op latency rules and checked every cycle.
module tb_fpu_op_sequencer;
    import fpu_pkg::*;

    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 12;

    logic       CLK;
    logic       RST;
    logic       FPU_OP;
    logic [3:0] FPU_CONTROL;
    logic       FLUSH;
    logic       STALL;
    logic       UNIT_START;
    logic [3:0] UNIT_CTRL;
    logic       FREG_WE;
    logic       XREG_WE;
    logic       ILLEGAL;
    fpu_state_e dbg_state;

    int checks;
    int failures;
    int cyc_num;

    // Observation counters since the last mark()
    int mon_cyc;
    int mon_stall;
    int mon_start_cyc;
    int mon_freg_cyc;
    int mon_freg_cnt;
    int mon_xreg_cyc;

    logic [8:0] exp_q[$];

    fpu_op_sequencer #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .FPU_OP      (FPU_OP),
        .FPU_CONTROL (FPU_CONTROL),
        .FLUSH       (FLUSH),
        .STALL       (STALL),
        .UNIT_START  (UNIT_START),
        .UNIT_CTRL   (UNIT_CTRL),
        .FREG_WE     (FREG_WE),
        .XREG_WE     (XREG_WE),
        .ILLEGAL     (ILLEGAL),
        .dbg_state   (dbg_state)
    );

    // Clock and reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [8:0] vec(input bit stall, input bit start, input logic [3:0] ctrl,
                                       input bit freg, input bit xreg, input bit ill);
        return {stall, start, ctrl, freg, xreg, ill};
    endfunction

    task automatic check_lit(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic mark();
        mon_cyc       = 0;
        mon_stall     = 0;
        mon_start_cyc = 0;
        mon_freg_cyc  = 0;
        mon_freg_cnt  = 0;
        mon_xreg_cyc  = 0;
    endtask

    // Driver plus per-cycle compare: apply one cycle of inputs, check outputs mid-cycle.
    task automatic drive(input bit op, input logic [3:0] code, input bit flush,
                         input bit rst_n, input logic [8:0] exp);
        logic [8:0] act;
        logic [8:0] e;
        exp_q.push_back(exp);
        FPU_OP      = op;
        FPU_CONTROL = code;
        FLUSH       = flush;
        RST         = rst_n;
        @(negedge CLK);
        cyc_num++;
        e   = exp_q.pop_front();
        act = {STALL, UNIT_START, UNIT_CTRL, FREG_WE, XREG_WE, ILLEGAL};
        checks++;
        if (act !== e) begin
            failures++;
            $display("FAIL outputs cycle=%0d {stall,start,ctrl,freg,xreg,ill} actual=%b required=%b",
                     cyc_num, act, e);
        end
        mon_cyc++;
        if (STALL === 1'b1) mon_stall++;
        if (UNIT_START === 1'b1) mon_start_cyc = mon_cyc;
        if (FREG_WE === 1'b1) begin
            mon_freg_cnt++;
            mon_freg_cyc = mon_cyc;
        end
        if (XREG_WE === 1'b1) mon_xreg_cyc = mon_cyc;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        logic [3:0] c;
        for (int i = 0; i < n; i++) begin
            c = 4'($urandom_range(0, 15));
            drive(1'b0, c, 1'b0, 1'b1, vec(0, 0, c, 0, 0, 0));
        end
    endtask

    task automatic reset_cycles(input int n);
        logic [3:0] c;
        for (int i = 0; i < n; i++) begin
            c = 4'($urandom_range(0, 15));
            drive(1'b1, c, 1'b0, 1'b0, vec(0, 0, c, 0, 0, 0));
        end
    endtask

    // Model: one instruction issued and held while stalled. abort_at (1-based
    // cycle within the instruction, 0 = none) applies FLUSH or a reset pulse.
    task automatic run_op(input logic [3:0] code, input int abort_at, input bit abort_rst);
        int  lat;
        int  n;
        bit  multi;
        bit  xwb;
        bit  ill;
        multi = (code == 4'd2) || (code == 4'd3);
        lat   = (code == 4'd3) ? DIV_LAT : MUL_LAT;
        n     = multi ? lat + 2 : 1;
        xwb   = (code == 4'd4) || (code == 4'd5) || (code == 4'd6) ||
                (code == 4'd8) || (code == 4'd10);
        ill   = (code >= 4'd14);
        for (int k = 1; k <= n; k++) begin
            if (k == abort_at) begin
                if (abort_rst) drive(1'b1, code, 1'b0, 1'b0, vec(0, 0, code, 0, 0, 0));
                else           drive(1'b1, code, 1'b1, 1'b1, vec(0, 0, code, 0, 0, 0));
                break;
            end
            if (multi)
                drive(1'b1, code, 1'b0, 1'b1,
                      vec(k <= lat + 1, k == 1, code, k == lat + 2, 0, 0));
            else
                drive(1'b1, code, 1'b0, 1'b1,
                      vec(0, 0, code, !ill && !xwb, !ill && xwb, ill));
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cyc_num  = 0;
        mark();
        FPU_OP      = 1'b0;
        FPU_CONTROL = 4'd0;
        FLUSH       = 1'b0;
        RST         = 1'b0;

        reset_cycles(2);
        check_lit("reset_state", int'(dbg_state), int'(ST_IDLE));
        idle(2);

        // add: same-cycle FREG write, no stall, state stays IDLE
        mark();
        run_op(4'd0, 0, 1'b0);
        check_lit("add_state_idle", int'(dbg_state), int'(ST_IDLE));
        check_lit("add_freg_cycle", mon_freg_cyc, 1);
        check_lit("add_stall_cycles", mon_stall, 0);

        // every other single-cycle code, then the two invalid codes
        for (int c = 1; c <= 13; c++) begin
            if (c != 2 && c != 3) run_op(4'(c), 0, 1'b0);
        end
        run_op(4'd14, 0, 1'b0);
        run_op(4'd15, 0, 1'b0);
        idle(1);

        // divide with DIV_LAT=12
        mark();
        run_op(4'd3, 0, 1'b0);
        check_lit("div_stall_cycles", mon_stall, 13);
        check_lit("div_start_cycle", mon_start_cyc, 1);
        check_lit("div_freg_cycle", mon_freg_cyc, 14);
        check_lit("div_freg_count", mon_freg_cnt, 1);

        // multiply then compare back-to-back
        mark();
        run_op(4'd2, 0, 1'b0);
        run_op(4'd4, 0, 1'b0);
        check_lit("mul_stall_cycles", mon_stall, 3);
        check_lit("mul_freg_cycle", mon_freg_cyc, 4);
        check_lit("cmp_xreg_cycle", mon_xreg_cyc, 5);
        idle(1);

        // FLUSH in BUSY cycle 5 of a divide (instruction cycle 6)
        mark();
        run_op(4'd3, 6, 1'b0);
        check_lit("flush_state_idle", int'(dbg_state), int'(ST_IDLE));
        idle(15);
        check_lit("flush_no_freg", mon_freg_cnt, 0);

        // FLUSH on issue of single and multi-cycle ops, and mid-multiply
        run_op(4'd0, 1, 1'b0);
        run_op(4'd2, 1, 1'b0);
        run_op(4'd2, 3, 1'b0);
        run_op(4'd5, 0, 1'b0);
        idle(1);

        // reset mid-divide, then single-cycle sub after release
        mark();
        run_op(4'd3, 5, 1'b1);
        reset_cycles(1);
        check_lit("rst_state_idle", int'(dbg_state), int'(ST_IDLE));
        idle(1);
        run_op(4'd1, 0, 1'b0);
        check_lit("rst_no_div_freg", mon_freg_cnt, 1);
        check_lit("rst_sub_freg_cycle", mon_freg_cyc, mon_cyc);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
